// File: rtl/uart_tx_param.sv
// Purpose : parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity, 1-2 stop bits).
// Latency : character accepted at edge k from IDLE drives the start bit from edge k+1.
// Backpr. : one-entry holding buffer; ready=0 while it is full, and enable is ignored then.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset (release must be synchronised by the integrator)
//   din     character to send, DATA_BITS wide
//   enable  write strobe; a character is accepted on an edge where enable && ready
//   ready   holding buffer empty
//   tx      serial line, idle high, registered
//   busy    high while a frame is in progress
//   done    one-clk pulse following the last clk of each frame's stop period
module uart_tx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 enable,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  // Guard keeps the counter at least one bit wide so an illegal BAUD_DIV
  // still reaches the parameter check below instead of a width error.
  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  // Parameter legality: stop elaboration on anything the datapath cannot honour.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  logic                 bit_end;
  logic                 frame_end;
  logic                 load;
  logic                 accept;
  logic                 par_calc;

  assign ready    = !hold_valid;
  assign accept   = enable && !hold_valid;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  // Last clk of the final stop bit: the frame is complete on this edge.
  assign frame_end = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
  // Load straight from IDLE, or chain directly out of STOP so consecutive
  // frames have no idle clocks between them. load needs hold_valid=1, which
  // means ready=0, so accept and load are never on the same edge.
  assign load = hold_valid && ((state == S_IDLE) || frame_end);

  // Odd parity: data plus parity bit carry an odd number of ones.
  assign par_calc = (PARITY == 1) ? ~(^hold_data) : (^hold_data);

  // Holding buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= din;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Frame sequencer. tx, busy and done are all registered here so the line
  // never glitches. The shift register is pre-shifted when a bit is emitted,
  // so shift[0] always holds the next data bit to drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state    <= S_START;
        shift    <= hold_data;
        par_bit  <= par_calc;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        tx       <= 1'b0;
        busy     <= 1'b1;
        // Chained load out of STOP still marks the end of the previous frame.
        done     <= frame_end;
      end else begin
        case (state)
          S_IDLE: begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
          end

          S_START: begin
            if (bit_end) begin
              state    <= S_DATA;
              baud_cnt <= '0;
              bit_cnt  <= '0;
              tx       <= shift[0];
              shift    <= shift >> 1;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          S_DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (HAS_PARITY) begin
                  state <= S_PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= S_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shift[0];
                shift   <= shift >> 1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          S_PARITY: begin
            if (bit_end) begin
              state    <= S_STOP;
              baud_cnt <= '0;
              bit_cnt  <= '0;
              tx       <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          S_STOP: begin
            tx <= 1'b1;
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                // Nothing waiting (load would have fired otherwise): go idle.
                state   <= S_IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          default: begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int NI = 4;

  // Instance configurations: 0 = 8N1/16, 1 = 7O2/16, 2 = 8E1/16, 3 = defaults.
  function automatic int div_of(int i);
    return (i == 3) ? 5208 : 16;
  endfunction
  function automatic int nb_of(int i);
    return (i == 1) ? 7 : 8;
  endfunction
  function automatic int par_of(int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int stp_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int flen(int i);
    return 1 + nb_of(i) + ((par_of(i) != 0) ? 1 : 0) + stp_of(i);
  endfunction

  logic       clk = 1'b0;
  logic       rst_n  [NI];
  logic       en     [NI];
  logic [8:0] din    [NI];
  logic       tx_o   [NI];
  logic       busy_o [NI];
  logic       done_o [NI];
  logic       rdy_o  [NI];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n[0]), .din(din[0][7:0]), .enable(en[0]),
    .ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n[1]), .din(din[1][6:0]), .enable(en[1]),
    .ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n[2]), .din(din[2][7:0]), .enable(en[2]),
    .ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]));
  uart_tx_param u_dflt (
    .clk(clk), .rst_n(rst_n[3]), .din(din[3][7:0]), .enable(en[3]),
    .ready(rdy_o[3]), .tx(tx_o[3]), .busy(busy_o[3]), .done(done_o[3]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each frame is a bit vector; the line value at any clk is the vector
  // entry at (clks since frame start) / BAUD_DIV.
  int         cyc = 0;
  bit         m_hv    [NI];
  logic [8:0] m_hd    [NI];
  bit         m_act   [NI];
  int         m_start [NI];
  logic [8:0] m_cur   [NI];
  bit         m_done  [NI];
  int         m_acc   [NI];

  function automatic logic frame_bit(int i, logic [8:0] d, int idx);
    int ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= nb_of(i)) return d[idx-1];
    if (par_of(i) != 0 && idx == nb_of(i) + 1) begin
      for (int b = 0; b < nb_of(i); b++) ones += int'(d[b]);
      return (par_of(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  function automatic void model_clear(int i);
    m_hv[i]   = 1'b0;
    m_hd[i]   = '0;
    m_act[i]  = 1'b0;
    m_done[i] = 1'b0;
    m_cur[i]  = '0;
  endfunction

  always @(posedge clk) begin
    bit acc;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        model_clear(i);
      end else begin
        acc = en[i] && !m_hv[i];
        m_done[i] = 1'b0;
        if (m_act[i] && (cyc - m_start[i] == flen(i) * div_of(i))) begin
          m_done[i] = 1'b1;
          m_act[i]  = 1'b0;
        end
        if (!m_act[i] && m_hv[i]) begin
          m_act[i]   = 1'b1;
          m_start[i] = cyc;
          m_cur[i]   = m_hd[i];
          m_hv[i]    = 1'b0;
        end
        if (acc) begin
          m_hv[i] = 1'b1;
          m_hd[i] = din[i] & 9'((1 << nb_of(i)) - 1);
          m_acc[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic etx;
    for (int i = 0; i < NI; i++) begin
      etx = m_act[i] ? frame_bit(i, m_cur[i], (cyc - m_start[i]) / div_of(i)) : 1'b1;
      check($sformatf("tx[%0d]", i),    int'(tx_o[i]),   int'(etx));
      check($sformatf("busy[%0d]", i),  int'(busy_o[i]), int'(m_act[i]));
      check($sformatf("done[%0d]", i),  int'(done_o[i]), int'(m_done[i]));
      check($sformatf("ready[%0d]", i), int'(rdy_o[i]),  int'(!m_hv[i]));
    end
  end

  // ---------------- capture helpers ----------------
  bit         cap_tx   [0:399];
  bit         cap_busy [0:399];
  bit         cap_done [0:399];
  bit         cap_rdy  [0:399];
  int         wr_at [$];
  logic [8:0] wr_d  [$];

  // Sample n edges; writes scheduled at k are presented for edge k+1.
  task automatic capture(int i, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cap_tx[k]   = tx_o[i];
      cap_busy[k] = busy_o[i];
      cap_done[k] = done_o[i];
      cap_rdy[k]  = rdy_o[i];
      en[i] = 1'b0;
      for (int w = 0; w < wr_at.size(); w++)
        if (wr_at[w] == k) begin en[i] = 1'b1; din[i] = wr_d[w]; end
    end
    en[i] = 1'b0;
    wr_at.delete();
    wr_d.delete();
  endtask

  function automatic int decode(int i, int s);
    int d = 0;
    for (int b = 0; b < nb_of(i); b++)
      if (cap_tx[s + (b + 1) * div_of(i) + div_of(i) / 2]) d |= (1 << b);
    return d;
  endfunction

  function automatic int count_busy(int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(cap_busy[k]);
    return c;
  endfunction

  function automatic int count_done(int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(cap_done[k]);
    return c;
  endfunction

  function automatic int nth_done(int n, int which);
    int c = 0;
    for (int k = 0; k < n; k++)
      if (cap_done[k]) begin
        if (c == which) return k;
        c++;
      end
    return -1;
  endfunction

  task automatic send(int i, logic [8:0] d);
    int t = 0;
    while (!rdy_o[i] && t < 2000) begin @(posedge clk); #1; t++; end
    check($sformatf("send_ready_wait[%0d]", i), int'(rdy_o[i]), 1);
    en[i] = 1'b1;
    din[i] = d;
    @(posedge clk); #1;
    en[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int t = 0;
    while ((busy_o[i] || !rdy_o[i]) && t < 3000) begin @(posedge clk); #1; t++; end
    check($sformatf("idle_wait[%0d]", i), int'(!busy_o[i] && rdy_o[i]), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] exp55;
    int dn;
    int acc0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b0; din[i] = '0; m_acc[i] = 0;
      model_clear(i);
    end
    #12;
    check("reset_tx",    int'(tx_o[0]),   1);
    check("reset_busy",  int'(busy_o[0]), 0);
    check("reset_done",  int'(done_o[0]), 0);
    check("reset_ready", int'(rdy_o[0]),  1);
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

    fork
      begin
        // 8N1, 0x55
        exp55 = 10'b1010101010;
        wr_at.push_back(0); wr_d.push_back(9'h55);
        capture(0, 200);
        check("a_accept_ready_low", int'(cap_rdy[1]), 0);
        check("a_tx_before_start",  int'(cap_tx[1]),  1);
        check("a_start_latency",    int'(cap_tx[2]),  0);
        check("a_ready_after_load", int'(cap_rdy[2]), 1);
        for (int b = 0; b < 10; b++)
          check($sformatf("a_bit%0d", b), int'(cap_tx[2 + b * 16 + 8]), int'(exp55[b]));
        check("a_busy_clks",  count_busy(200), 160);
        check("a_done_count", count_done(200), 1);
        check("a_done_at",    nth_done(200, 0), 162);

        // 7O2, 0x41
        wr_at.push_back(0); wr_d.push_back(9'h41);
        capture(1, 200);
        check("b_parity_bit", int'(cap_tx[138]), 1);
        check("b_data",       decode(1, 2), 'h41);
        check("b_busy_clks",  count_busy(200), 176);
        check("b_done_at",    nth_done(200, 0), 178);
        dn = 0;
        for (int k = 146; k < 178; k++) dn += int'(cap_tx[k]);
        check("b_stop_high_clks", dn, 32);

        // 8E1, 0x07 then 0x03
        wr_at.push_back(0); wr_d.push_back(9'h07);
        capture(2, 200);
        check("c_parity_07", int'(cap_tx[154]), 1);
        wr_at.push_back(0); wr_d.push_back(9'h03);
        capture(2, 200);
        check("c_parity_03", int'(cap_tx[154]), 0);

        // Streaming: third write lands while the buffer is full.
        wr_at.push_back(0);  wr_d.push_back(9'hA5);
        wr_at.push_back(20); wr_d.push_back(9'h3C);
        wr_at.push_back(40); wr_d.push_back(9'hFF);
        capture(0, 340);
        check("s_done_count",    count_done(340), 2);
        check("s_done_gap",      nth_done(340, 1) - nth_done(340, 0), 160);
        check("s_busy_clks",     count_busy(340), 320);
        check("s_stop_then_start", int'({cap_tx[161], cap_tx[162]}), 2);
        check("s_first_data",    decode(0, 2), 'hA5);
        check("s_second_data",   decode(0, 162), 'h3C);

        // Reset mid-DATA with a character also held.
        wr_at.push_back(0);  wr_d.push_back(9'h00);
        wr_at.push_back(10); wr_d.push_back(9'hAA);
        capture(0, 52);
        @(posedge clk); #2;
        check("r_tx_before",    int'(tx_o[0]),   0);
        check("r_busy_before",  int'(busy_o[0]), 1);
        check("r_ready_before", int'(rdy_o[0]),  0);
        rst_n[0] = 1'b0;
        model_clear(0);
        #1;
        check("r_tx_async",    int'(tx_o[0]),   1);
        check("r_busy_async",  int'(busy_o[0]), 0);
        check("r_ready_async", int'(rdy_o[0]),  1);
        repeat (3) @(posedge clk);
        #1 rst_n[0] = 1'b1;
        wr_at.push_back(0); wr_d.push_back(9'h81);
        capture(0, 200);
        check("r_clean_latency", int'(cap_tx[2]), 0);
        check("r_clean_data",    decode(0, 2), 'h81);
        check("r_clean_frames",  count_done(200), 1);

        // enable held high with din changing every clk.
        acc0 = m_acc[0];
        dn = 0;
        en[0] = 1'b1;
        for (int k = 0; k < 1000; k++) begin
          din[0] = 9'($urandom_range(0, 255));
          @(posedge clk); #1;
          dn += int'(done_o[0]);
        end
        en[0] = 1'b0;
        for (int k = 0; k < 400; k++) begin
          @(posedge clk); #1;
          dn += int'(done_o[0]);
        end
        check("held_frames_vs_accepts", dn, m_acc[0] - acc0);

        // Random characters and gaps on the small-divider instances.
        for (int i = 0; i < 3; i++) begin
          for (int n = 0; n < 12; n++) begin
            send(i, 9'($urandom_range(0, 511)));
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 200)) @(posedge clk);
            #1;
          end
          wait_idle(i);
        end
      end

      begin
        // Default divider: start bit length, then abort by reset.
        int t;
        int low;
        t = 0;
        low = 0;
        en[3] = 1'b1;
        din[3] = 9'h01;
        @(posedge clk); #1;
        en[3] = 1'b0;
        while (tx_o[3] && t < 20) begin @(posedge clk); #1; t++; end
        check("d_start_seen", int'(tx_o[3]), 0);
        while (!tx_o[3] && low < 6000) begin @(posedge clk); #1; low++; end
        check("d_bit_clks", low, 5208);
        rst_n[3] = 1'b0;
        model_clear(3);
        repeat (2) @(posedge clk);
        #1 rst_n[3] = 1'b1;
      end
    join

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
